// File: rtl/nit_capture.sv
// nit_capture: collects one PSI section group on CAP_PID from the 32-bit TS bus and replays
// it as a packet-count header byte followed by the raw 188-byte packets.
module nit_capture #(
    parameter logic [12:0] CAP_PID  = 13'h0010,
    parameter int unsigned MAX_PACK = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ts_din,
    input  logic        i_ts_din_en,
    output logic [7:0]  o_nit_dout,
    output logic        o_nit_dout_en,
    output logic        o_busy
);
    localparam int unsigned Words = MAX_PACK * 47;
    localparam int unsigned WAW   = $clog2(Words);
    localparam int unsigned BAW   = WAW + 2;

    typedef enum logic [1:0] {StHunt, StCapture, StEmit} state_e;

    state_e          r_state, w_state_d;
    logic [5:0]      r_wcnt;
    logic            r_en_d;
    logic            r_acc, w_acc_d;
    logic [3:0]      r_cur_cc, w_cur_cc_d;
    logic [3:0]      r_last_cc, w_last_cc_d;
    logic [3:0]      r_num, w_num_d;
    logic [WAW-1:0]  r_base, w_base_d;
    logic [BAW-1:0]  r_ecnt, w_ecnt_d;
    logic [7:0]      r_dout, w_dout_d;
    logic            r_dout_en, w_dout_en_d;
    logic            r_busy;
    logic            w_we;
    logic [31:0]     r_mem [Words];

    logic            w_word0, w_match, w_pusi, w_cc_ok, w_fall, w_valid, w_close_max;
    logic [3:0]      w_cc, w_num_inc;
    logic [WAW-1:0]  w_waddr, w_rword;
    logic [BAW-1:0]  w_rbaddr, w_nbytes;
    logic [31:0]     w_rdata;
    logic [7:0]      w_rbyte;

    assign w_word0     = i_ts_din_en && (r_wcnt == 6'd0);
    assign w_match     = (i_ts_din[31:24] == 8'h47) && !i_ts_din[23] &&
                         (i_ts_din[20:8] == CAP_PID);
    assign w_pusi      = i_ts_din[22];
    assign w_cc        = i_ts_din[3:0];
    assign w_cc_ok     = (w_cc == r_last_cc + 4'd1);
    assign w_fall      = !i_ts_din_en && r_en_d;
    assign w_valid     = (r_wcnt == 6'd47);
    assign w_num_inc   = r_num + 4'd1;
    assign w_close_max = (32'(w_num_inc) == MAX_PACK);
    assign w_waddr     = r_base + WAW'(r_wcnt);

    // Byte address of the emitted data byte; slots are contiguous so word = byte / 4.
    assign w_rbaddr = (r_ecnt == '0) ? '0 : r_ecnt - BAW'(1);
    assign w_rword  = w_rbaddr[BAW-1:2];
    assign w_rdata  = r_mem[w_rword];
    assign w_nbytes = BAW'(r_num) * BAW'(188);

    always_comb begin
        w_rbyte = w_rdata[31:24];
        case (w_rbaddr[1:0])
            2'd1:    w_rbyte = w_rdata[23:16];
            2'd2:    w_rbyte = w_rdata[15:8];
            2'd3:    w_rbyte = w_rdata[7:0];
            default: w_rbyte = w_rdata[31:24];
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_acc_d     = r_acc;
        w_cur_cc_d  = r_cur_cc;
        w_last_cc_d = r_last_cc;
        w_num_d     = r_num;
        w_base_d    = r_base;
        w_ecnt_d    = r_ecnt;
        w_we        = 1'b0;
        w_dout_d    = 8'h00;
        w_dout_en_d = 1'b0;
        unique case (r_state)
            StHunt: begin
                if (w_word0 && w_match && w_pusi) begin
                    w_state_d  = StCapture;
                    w_acc_d    = 1'b1;
                    w_cur_cc_d = w_cc;
                    w_we       = 1'b1;
                    w_num_d    = 4'd0;
                    w_base_d   = '0;
                end
            end
            StCapture: begin
                if (w_fall && r_acc) begin
                    w_acc_d = 1'b0;
                    if (w_valid) begin
                        w_num_d     = w_num_inc;
                        w_base_d    = r_base + WAW'(47);
                        w_last_cc_d = r_cur_cc;
                        if (w_close_max) begin
                            w_state_d = StEmit;
                            w_ecnt_d  = '0;
                        end
                    end else begin
                        w_state_d = StHunt;
                        w_num_d   = 4'd0;
                        w_base_d  = '0;
                    end
                end else if (w_word0 && w_match) begin
                    if (w_pusi) begin
                        // Next group's PUSI closes this one and is itself dropped.
                        w_state_d = StEmit;
                        w_ecnt_d  = '0;
                    end else if (w_cc_ok) begin
                        w_acc_d    = 1'b1;
                        w_cur_cc_d = w_cc;
                        w_we       = 1'b1;
                    end else begin
                        w_state_d = StHunt;
                        w_num_d   = 4'd0;
                        w_base_d  = '0;
                    end
                end else if (r_acc && i_ts_din_en && (r_wcnt < 6'd47)) begin
                    w_we = 1'b1;
                end
            end
            StEmit: begin
                w_dout_en_d = 1'b1;
                w_dout_d    = (r_ecnt == '0) ? {4'h0, r_num} : w_rbyte;
                w_ecnt_d    = r_ecnt + BAW'(1);
                if (r_ecnt == w_nbytes) begin
                    w_state_d = StHunt;
                    w_num_d   = 4'd0;
                    w_base_d  = '0;
                end
            end
            default: w_state_d = StHunt;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StHunt;
            r_wcnt    <= 6'd0;
            r_en_d    <= 1'b0;
            r_acc     <= 1'b0;
            r_cur_cc  <= 4'd0;
            r_last_cc <= 4'd0;
            r_num     <= 4'd0;
            r_base    <= '0;
            r_ecnt    <= '0;
            r_dout    <= 8'h00;
            r_dout_en <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            if (!i_ts_din_en) begin
                r_wcnt <= 6'd0;
            end else if (r_wcnt != 6'h3f) begin
                r_wcnt <= r_wcnt + 6'd1;
            end
            r_en_d    <= i_ts_din_en;
            r_state   <= w_state_d;
            r_acc     <= w_acc_d;
            r_cur_cc  <= w_cur_cc_d;
            r_last_cc <= w_last_cc_d;
            r_num     <= w_num_d;
            r_base    <= w_base_d;
            r_ecnt    <= w_ecnt_d;
            r_dout    <= w_dout_d;
            r_dout_en <= w_dout_en_d;
            // Held through the final EMIT cycle so busy drops together with the strobe.
            r_busy    <= (w_state_d != StHunt) || (r_state == StEmit);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= i_ts_din;
        end
    end

    assign o_nit_dout    = r_dout;
    assign o_nit_dout_en = r_dout_en;
    assign o_busy        = r_busy;
endmodule

// File: tb/tb_nit_capture.sv
// Bench for nit_capture: packet-level group model predicts each burst, checked byte-for-byte.
module tb_nit_capture;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ts_din;
    logic        en_a, en_b;
    logic [7:0]  dout_a, dout_b;
    logic        den_a, den_b, busy_a, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int ecyc  = 0;
    int idle_bad [2];

    logic [7:0] q_obs0 [$];
    logic [7:0] q_obs1 [$];
    logic [7:0] q_exp0 [$];
    logic [7:0] q_exp1 [$];
    int         hdr0 [$];
    int         hdr1 [$];
    logic       prev_den0 = 1'b0;
    logic       prev_den1 = 1'b0;

    bit         m_hunt [2];
    bit         m_emit [2];
    int         m_npk  [2];
    logic [3:0] m_lcc  [2];
    int         m_nb   [2];
    int         m_max  [2];
    logic [7:0] m_buf  [2][2820];

    always #5 clk = ~clk;
    always @(posedge clk) ecyc <= ecyc + 1;

    nit_capture #(.CAP_PID(13'h0010), .MAX_PACK(15)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ts_din(ts_din), .i_ts_din_en(en_a),
        .o_nit_dout(dout_a), .o_nit_dout_en(den_a), .o_busy(busy_a)
    );
    nit_capture #(.CAP_PID(13'h0010), .MAX_PACK(2)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ts_din(ts_din), .i_ts_din_en(en_b),
        .o_nit_dout(dout_b), .o_nit_dout_en(den_b), .o_busy(busy_b)
    );

    always @(negedge clk) begin
        if (den_a) begin
            if (!prev_den0) hdr0.push_back(ecyc);
            q_obs0.push_back(dout_a);
        end else if (dout_a !== 8'h00) begin
            idle_bad[0]++;
        end
        if (den_b) begin
            if (!prev_den1) hdr1.push_back(ecyc);
            q_obs1.push_back(dout_b);
        end else if (dout_b !== 8'h00) begin
            idle_bad[1]++;
        end
        prev_den0 = den_a;
        prev_den1 = den_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_hunt[s] = 1'b1;
            m_emit[s] = 1'b0;
            m_npk[s]  = 0;
            m_lcc[s]  = 4'd0;
            m_nb[s]   = 0;
        end
        m_max[0] = 15;
        m_max[1] = 2;
        q_obs0.delete(); q_obs1.delete(); q_exp0.delete(); q_exp1.delete();
        hdr0.delete(); hdr1.delete();
    endtask

    task automatic model_close(input int s);
        logic [7:0] hdr;
        hdr = {4'h0, 4'(m_npk[s])};
        if (s == 0) q_exp0.push_back(hdr); else q_exp1.push_back(hdr);
        for (int i = 0; i < m_npk[s] * 188; i++) begin
            if (s == 0) q_exp0.push_back(m_buf[s][i]); else q_exp1.push_back(m_buf[s][i]);
        end
        m_nb[s]++;
        m_emit[s] = 1'b1;
        m_hunt[s] = 1'b1;
        m_npk[s]  = 0;
    endtask

    task automatic model_add(input int s, input logic [7:0] b [188], input logic [3:0] cc);
        for (int i = 0; i < 188; i++) m_buf[s][m_npk[s] * 188 + i] = b[i];
        m_npk[s]++;
        m_lcc[s]  = cc;
        m_hunt[s] = 1'b0;
        if (m_npk[s] == m_max[s]) model_close(s);
    endtask

    // Group rules applied one whole packet at a time.
    task automatic model_pkt(input int s, input logic [7:0] b [188], input int nw,
                             input logic [12:0] pid, input bit tei, input bit pusi,
                             input logic [3:0] cc);
        bit match;
        match = (b[0] == 8'h47) && !tei && (pid == 13'h0010);
        if (!m_emit[s]) begin
            if (m_hunt[s]) begin
                if (match && pusi && nw == 47) begin
                    m_npk[s] = 0;
                    model_add(s, b, cc);
                end
            end else if (match) begin
                if (pusi) model_close(s);
                else if (cc == 4'(m_lcc[s] + 4'd1) && nw == 47) model_add(s, b, cc);
                else begin
                    m_hunt[s] = 1'b1;
                    m_npk[s]  = 0;
                end
            end
        end
    endtask

    task automatic send_pkt(input int s, input logic [7:0] sync, input logic [12:0] pid,
                            input bit tei, input bit pusi, input logic [3:0] cc, input int nw,
                            output int t0, output int tf);
        logic [7:0] b [188];
        for (int i = 0; i < 188; i++) b[i] = 8'($urandom);
        b[0] = sync;
        b[1] = {tei, pusi, 1'b0, pid[12:8]};
        b[2] = pid[7:0];
        b[3] = {4'h1, cc};
        t0 = 0;
        for (int w = 0; w < nw; w++) begin
            @(posedge clk); #1;
            if (w == 0) t0 = ecyc;
            ts_din = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
            if (s == 0) en_a = 1'b1; else en_b = 1'b1;
        end
        @(posedge clk); #1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        ts_din = $urandom;
        tf     = ecyc;
        model_pkt(s, b, nw, pid, tei, pusi, cc);
    endtask

    task automatic pkt(input int s, input bit pusi, input logic [3:0] cc, output int t0,
                       output int tf);
        send_pkt(s, 8'h47, 13'h0010, 1'b0, pusi, cc, 47, t0, tf);
    endtask

    task automatic wait_done(input int s, input string tag);
        int n;
        n = 0;
        if (m_emit[s]) begin
            do begin
                @(negedge clk);
                n++;
            end while (((s == 0) ? (busy_a || den_a) : (busy_b || den_b)) && n < 4000);
            chk({tag, "_done"}, 32'(n < 4000), 32'd1);
            m_emit[s] = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_burst(input int s, input string tag, input int t_close);
        int         bad;
        logic [7:0] o [$];
        logic [7:0] e [$];
        int         h [$];
        bad = 0;
        if (s == 0) begin o = q_obs0; e = q_exp0; h = hdr0; end
        else begin o = q_obs1; e = q_exp1; h = hdr1; end
        chk({tag, "_bursts"}, h.size(), m_nb[s]);
        chk({tag, "_len"}, o.size(), e.size());
        for (int i = 0; i < o.size() && i < e.size(); i++) if (o[i] !== e[i]) bad++;
        chk({tag, "_data"}, bad, 0);
        if (m_nb[s] == 1 && h.size() > 0) chk({tag, "_hdr_cycle"}, h[0], t_close + 2);
        if (s == 0) begin q_obs0.delete(); q_exp0.delete(); hdr0.delete(); end
        else begin q_obs1.delete(); q_exp1.delete(); hdr1.delete(); end
        m_nb[s] = 0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         t0, tf, tc, n;
        logic [3:0] cc;
        idle_bad[0] = 0;
        idle_bad[1] = 0;
        rst_n  = 1'b0;
        en_a   = 1'b0;
        en_b   = 1'b0;
        ts_din = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_dout_a", dout_a, 0);
        chk("reset_den_a", den_a, 0);
        chk("reset_busy_a", busy_a, 0);
        chk("reset_dout_b", dout_b, 0);
        chk("reset_den_b", den_b, 0);
        chk("reset_busy_b", busy_b, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-packet group closed by a back-to-back PUSI packet.
        pkt(0, 1'b1, 4'd5, t0, tf);
        pkt(0, 1'b1, 4'd6, tc, tf);
        wait_done(0, "single");
        check_burst(0, "single", tc);
        chk("single_busy_idle", busy_a, 0);

        // Three packets with CC wrap 14,15,0.
        pkt(0, 1'b1, 4'd14, t0, tf);
        repeat (2) @(negedge clk);
        chk("three_busy_rise", busy_a, 1);
        pkt(0, 1'b0, 4'd15, t0, tf);
        pkt(0, 1'b0, 4'd0, t0, tf);
        pkt(0, 1'b1, 4'd1, tc, tf);
        wait_done(0, "three");
        check_burst(0, "three", tc);

        // CC gap, then duplicate CC, then a fresh group.
        pkt(0, 1'b1, 4'd3, t0, tf);
        pkt(0, 1'b0, 4'd5, t0, tf);
        repeat (2) @(negedge clk);
        chk("disc_busy_drop", busy_a, 0);
        pkt(0, 1'b1, 4'd4, t0, tf);
        pkt(0, 1'b0, 4'd4, t0, tf);
        repeat (2) @(negedge clk);
        chk("dup_busy_drop", busy_a, 0);
        pkt(0, 1'b1, 4'd7, t0, tf);
        pkt(0, 1'b0, 4'd8, t0, tf);
        pkt(0, 1'b1, 4'd9, tc, tf);
        wait_done(0, "disc");
        check_burst(0, "disc", tc);

        // MAX_PACK=2 instance: packets 3 and 4 arrive during EMIT.
        pkt(1, 1'b1, 4'd0, t0, tf);
        pkt(1, 1'b0, 4'd1, t0, tc);
        pkt(1, 1'b0, 4'd2, t0, tf);
        pkt(1, 1'b0, 4'd3, t0, tf);
        wait_done(1, "maxpack");
        check_burst(1, "maxpack", tc);

        // Filtering: foreign PID, TEI, bad sync ignored; short packet aborts.
        pkt(0, 1'b1, 4'd1, t0, tf);
        send_pkt(0, 8'h47, 13'h0000, 1'b0, 1'b1, 4'd0, 47, t0, tf);
        send_pkt(0, 8'h47, 13'h0010, 1'b1, 1'b1, 4'd9, 47, t0, tf);
        send_pkt(0, 8'h46, 13'h0010, 1'b0, 1'b1, 4'd2, 47, t0, tf);
        pkt(0, 1'b0, 4'd2, t0, tf);
        repeat (2) @(negedge clk);
        chk("filter_busy_held", busy_a, 1);
        send_pkt(0, 8'h47, 13'h0010, 1'b0, 1'b0, 4'd3, 46, t0, tf);
        repeat (2) @(negedge clk);
        chk("short_busy_drop", busy_a, 0);
        wait_done(0, "filter");
        check_burst(0, "filter", 0);

        // Randomised groups with interleaved foreign traffic.
        for (int it = 0; it < 3; it++) begin
            n  = $urandom_range(1, 4);
            cc = 4'($urandom);
            pkt(0, 1'b1, cc, t0, tf);
            for (int k = 1; k < n; k++) begin
                if ($urandom_range(0, 1) == 1)
                    send_pkt(0, 8'h47, 13'($urandom_range(17, 8191)), 1'b0,
                             1'($urandom_range(0, 1)), 4'($urandom), 47, t0, tf);
                cc = cc + 4'd1;
                pkt(0, 1'b0, cc, t0, tf);
            end
            pkt(0, 1'b1, 4'($urandom), tc, tf);
            wait_done(0, "rand");
            check_burst(0, "rand", tc);
        end

        // Reset in the middle of a burst.
        pkt(0, 1'b1, 4'd9, t0, tf);
        pkt(0, 1'b0, 4'd10, t0, tf);
        pkt(0, 1'b1, 4'd11, tc, tf);
        n = 0;
        while (q_obs0.size() < 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_byte100", 32'(n < 2000), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_den_a", den_a, 0);
        chk("rst_dout_a", dout_a, 0);
        chk("rst_busy_a", busy_a, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pkt(0, 1'b0, 4'd12, t0, tf);
        repeat (60) @(negedge clk);
        chk("rst_no_output", q_obs0.size(), 0);
        chk("rst_busy_idle", busy_a, 0);
        pkt(0, 1'b1, 4'd2, t0, tf);
        pkt(0, 1'b1, 4'd3, tc, tf);
        wait_done(0, "after_rst");
        check_burst(0, "after_rst", tc);

        chk("idle_zero_a", idle_bad[0], 0);
        chk("idle_zero_b", idle_bad[1], 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
